// File: rtl/avg_window_if.sv
// Sample stream and averaged-output bundle for avg_window.
// The owner of the input stream uses master; the filter uses slave.
interface avg_window_if #(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 7
);
  localparam int LW = $clog2(MAX_LOG2 + 1);

  logic                    start_i;
  logic                    valid_i;
  logic signed [WIDTH-1:0] data_i;
  logic [LW-1:0]           win_log2_i;
  logic signed [WIDTH-1:0] data_o;
  logic                    valid_o;
  logic                    full_o;

  modport master (
    output start_i, valid_i, data_i, win_log2_i,
    input  data_o, valid_o, full_o
  );

  modport slave (
    input  start_i, valid_i, data_i, win_log2_i,
    output data_o, valid_o, full_o
  );
endinterface

// File: rtl/avg_window.sv
// Boxcar moving average over 2^L samples, L runtime-selectable up to MAX_LOG2.
// Optional round-half-up with saturation when AVG_ROUND_EN is defined.
module avg_window #(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 7
) (
  input  logic       clk,
  input  logic       rst,
  avg_window_if.slave bus
);
  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int AW    = WIDTH + MAX_LOG2;
  localparam int LW    = $clog2(MAX_LOG2 + 1);
  localparam int CW    = MAX_LOG2 + 1;
  localparam logic [LW-1:0] LMAX = LW'(MAX_LOG2);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [MAX_LOG2-1:0]     wr_ptr;
  logic [LW-1:0]           l_q, l_clamp, l_new;
  logic [CW-1:0]           cnt_q, cnt_next, win_q, win_new;
  logic signed [AW-1:0]    acc_q, acc_base, acc_next, oldest;
  logic signed [WIDTH-1:0] result;
  logic                    accept, flush, full_next, vld_q;

  function automatic logic signed [AW-1:0] sext(input logic signed [WIDTH-1:0] x);
    return {{MAX_LOG2{x[WIDTH-1]}}, x};
  endfunction

  // Only elaborate the clamp when the exponent field can exceed MAX_LOG2.
  if ((2**LW) - 1 > MAX_LOG2) begin : g_clamp
    assign l_clamp = (bus.win_log2_i > LMAX) ? LMAX : bus.win_log2_i;
  end else begin : g_noclamp
    assign l_clamp = bus.win_log2_i;
  end

  always_comb begin
    accept   = bus.start_i && bus.valid_i;
    flush    = bus.start_i && (l_clamp != l_q);
    l_new    = flush ? l_clamp : l_q;
    win_q    = CW'(1) << l_q;
    win_new  = CW'(1) << l_new;
    // Until the window is full the leaving sample is an implicit zero.
    oldest   = '0;
    if (!flush && cnt_q == win_q)
      oldest = sext(mem[wr_ptr - win_q[MAX_LOG2-1:0]]);
    acc_base = flush ? '0 : acc_q;
    cnt_next = flush ? '0 : cnt_q;
    acc_next = acc_base;
    if (accept) begin
      acc_next = acc_base + sext(bus.data_i) - oldest;
      if (cnt_next != win_new)
        cnt_next = cnt_next + CW'(1);
    end
    full_next = (cnt_next == win_new);
  end

`ifdef AVG_ROUND_EN
  logic signed [AW:0] rnd_sum, rnd_shf;

  always_comb begin
    rnd_sum = {acc_next[AW-1], acc_next}
            + ((l_new == '0) ? '0 : ((AW+1)'(1) << (l_new - LW'(1))));
    rnd_shf = rnd_sum >>> l_new;
    if (rnd_shf[AW:WIDTH-1] == '0 || rnd_shf[AW:WIDTH-1] == '1)
      result = rnd_shf[WIDTH-1:0];
    else if (rnd_shf[AW])
      result = {1'b1, {(WIDTH-1){1'b0}}};
    else
      result = {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  logic signed [AW-1:0] shf;

  always_comb begin
    shf    = acc_next >>> l_new;
    result = shf[WIDTH-1:0];
  end
`endif

  // Buffer is never cleared; the fill count hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && accept)
      mem[wr_ptr] <= bus.data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      wr_ptr      <= '0;
      cnt_q       <= '0;
      l_q         <= l_clamp;
      bus.data_o  <= '0;
      bus.full_o  <= 1'b0;
      vld_q       <= 1'b0;
    end else begin
      vld_q <= accept;
      if (bus.start_i) begin
        l_q   <= l_new;
        acc_q <= acc_next;
        cnt_q <= cnt_next;
        if (accept) begin
          wr_ptr     <= wr_ptr + 1'b1;
          bus.data_o <= result;
        end
        if (accept || flush)
          bus.full_o <= full_next;
      end
    end
  end

  assign bus.valid_o = vld_q;
endmodule

// File: tb/tb_avg_window.sv
// Directed bench for avg_window: reset, fill, step, gaps, wide range,
// window change, L=0, rounding and exponent clamp (second instance).
module tb_avg_window;
  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  avg_window_if #(.WIDTH(16), .MAX_LOG2(7)) bus ();
  avg_window_if #(.WIDTH(16), .MAX_LOG2(5)) bus5 ();

  avg_window #(.WIDTH(16), .MAX_LOG2(7)) dut  (.clk(clk), .rst(rst), .bus(bus));
  avg_window #(.WIDTH(16), .MAX_LOG2(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] l);
    bus.win_log2_i = l;
    bus.start_i    = 1'b0;
    bus.valid_i    = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic signed [15:0] d);
    bus.start_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.data_i  = 16'sd1234;
    bus.win_log2_i = 3'd2;
    for (int i = 0; i < 3; i++) begin
      bus.valid_i = i[0];
      tick();
      vecs++;
      if ({bus.data_o, bus.valid_o, bus.full_o} !== 18'd0) begin
        errs++;
        $display("FAIL reset[%0d]: got data=%0d valid=%b full=%b, want 0 0 0",
                 i, bus.data_o, bus.valid_o, bus.full_o);
      end
    end
    rst = 1'b0;
    bus.valid_i = 1'b0;
  endtask

  task automatic test_fill();
    logic signed [15:0] exp [6] = '{25, 50, 75, 100, 100, 100};
    do_reset(3'd2);
    for (int i = 0; i < 6; i++) begin
      push(16'sd100);
      vecs++;
      if (bus.data_o !== exp[i] || bus.valid_o !== 1'b1 || bus.full_o !== (i >= 3)) begin
        errs++;
        $display("FAIL fill[%0d]: got data=%0d valid=%b full=%b, want %0d 1 %b",
                 i, bus.data_o, bus.valid_o, bus.full_o, exp[i], i >= 3);
      end
    end
    bus.start_i = 1'b1;
    tick();
    vecs++;
    if (bus.valid_o !== 1'b0) begin
      errs++;
      $display("FAIL fill_valid_lag: got valid=%b, want 0", bus.valid_o);
    end
  endtask

  task automatic test_step_gaps();
    logic signed [15:0] din [9] = '{100, 100, 100, 100, -8, -8, -8, -8, -8};
    logic signed [15:0] exp [9] = '{25, 50, 75, 100, 73, 46, 19, -8, -8};
    for (int run = 0; run < 2; run++) begin
      do_reset(3'd2);
      for (int i = 0; i < 9; i++) begin
        push(din[i]);
        vecs++;
        if (bus.data_o !== exp[i] || bus.valid_o !== 1'b1) begin
          errs++;
          $display("FAIL step run%0d[%0d]: got data=%0d valid=%b, want %0d 1",
                   run, i, bus.data_o, bus.valid_o, exp[i]);
        end
        if (run == 1) begin
          for (int g = 0; g < 4; g++) begin
            // Three idle cycles, then a paused cycle with valid_i high.
            bus.start_i = (g < 3);
            bus.valid_i = (g == 3);
            bus.data_i  = 16'sd999;
            tick();
            vecs++;
            if (bus.valid_o !== 1'b0 || bus.data_o !== exp[i]) begin
              errs++;
              $display("FAIL gap[%0d.%0d]: got data=%0d valid=%b, want %0d 0",
                       i, g, bus.data_o, bus.valid_o, exp[i]);
            end
          end
          bus.valid_i = 1'b0;
        end
      end
    end
  endtask

  task automatic test_wide();
    logic signed [15:0] prev;
    int bad;
    do_reset(3'd7);
    for (int i = 0; i < 128; i++) push(16'sd32767);
    vecs++;
    if (bus.data_o !== 16'sd32767 || bus.full_o !== 1'b1) begin
      errs++;
      $display("FAIL wide_pos: got data=%0d full=%b, want 32767 1", bus.data_o, bus.full_o);
    end
    push(-16'sd32768);
    vecs++;
    if (bus.data_o !== 16'sd32255) begin
      errs++;
      $display("FAIL wide_first_neg: got %0d, want 32255", bus.data_o);
    end
    prev = bus.data_o;
    bad  = 0;
    for (int i = 1; i < 128; i++) begin
      push(-16'sd32768);
      if (bus.data_o > prev) bad++;
      prev = bus.data_o;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL wide_monotonic: got %0d increases, want 0", bad);
    end
    vecs++;
    if (bus.data_o !== -16'sd32768 || bus.full_o !== 1'b1) begin
      errs++;
      $display("FAIL wide_neg: got data=%0d full=%b, want -32768 1", bus.data_o, bus.full_o);
    end
  endtask

  task automatic test_win_change();
    do_reset(3'd2);
    for (int i = 0; i < 6; i++) push(16'sd80);
    vecs++;
    if (bus.data_o !== 16'sd80 || bus.full_o !== 1'b1) begin
      errs++;
      $display("FAIL winchg_pre: got data=%0d full=%b, want 80 1", bus.data_o, bus.full_o);
    end
    bus.win_log2_i = 3'd3;
    for (int i = 0; i < 8; i++) begin
      push(16'sd80);
      vecs++;
      if (bus.data_o !== 16'(10 * (i + 1)) || bus.full_o !== (i == 7)) begin
        errs++;
        $display("FAIL winchg[%0d]: got data=%0d full=%b, want %0d %b",
                 i, bus.data_o, bus.full_o, 10 * (i + 1), i == 7);
      end
    end
  endtask

  task automatic test_l0();
    logic signed [15:0] din [3] = '{5, -7, 300};
    do_reset(3'd0);
    for (int i = 0; i < 3; i++) begin
      push(din[i]);
      vecs++;
      if (bus.data_o !== din[i] || bus.full_o !== 1'b1) begin
        errs++;
        $display("FAIL l0[%0d]: got data=%0d full=%b, want %0d 1",
                 i, bus.data_o, bus.full_o, din[i]);
      end
    end
  endtask

  task automatic test_round();
    logic signed [15:0] din [4] = '{1, 1, -1, -1};
`ifdef AVG_ROUND_EN
    logic signed [15:0] exp [4] = '{0, 1, 0, 0};
    logic signed [15:0] exp1 = 0;
`else
    logic signed [15:0] exp [4] = '{0, 0, 0, 0};
    logic signed [15:0] exp1 = -1;
`endif
    do_reset(3'd2);
    for (int i = 0; i < 4; i++) begin
      push(din[i]);
      vecs++;
      if (bus.data_o !== exp[i]) begin
        errs++;
        $display("FAIL round_l2[%0d]: got %0d, want %0d", i, bus.data_o, exp[i]);
      end
    end
    do_reset(3'd1);
    push(-16'sd1);
    vecs++;
    if (bus.data_o !== exp1) begin
      errs++;
      $display("FAIL round_l1: got %0d, want %0d", bus.data_o, exp1);
    end
  endtask

  task automatic test_clamp();
    bus5.win_log2_i = 3'd7;
    bus5.start_i    = 1'b0;
    bus5.valid_i    = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus5.start_i = 1'b1;
    bus5.valid_i = 1'b1;
    bus5.data_i  = 16'sd64;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 0 || i >= 30) begin
        vecs++;
        if (bus5.data_o !== 16'(2 * (i + 1)) || bus5.full_o !== (i == 31)) begin
          errs++;
          $display("FAIL clamp[%0d]: got data=%0d full=%b, want %0d %b",
                   i, bus5.data_o, bus5.full_o, 2 * (i + 1), i == 31);
        end
      end
    end
    bus5.start_i = 1'b0;
    bus5.valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;  bus.valid_i = 1'b0;  bus.data_i = '0;  bus.win_log2_i = '0;
    bus5.start_i = 1'b0; bus5.valid_i = 1'b0; bus5.data_i = '0; bus5.win_log2_i = '0;
    test_reset();
    test_fill();
    test_step_gaps();
    test_wide();
    test_win_change();
    test_l0();
    test_round();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
